alu_pipe_mul: RTL and testbench

//   Parametrised successor to the single-cycle EXE-stage ALU. Registers every result behind a

---
 rtl/alu_pipe_mul.sv | 170 +++++++++++++++++
 tb/tb_alu_pipe_mul.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mul.sv
// EXE-stage ALU with registered result/flags behind a valid/ready handshake,
// plus an iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
module alu_pipe_mul #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic             carry,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       sr
);

  localparam int N_ITER = WIDTH / MUL_STEP;
  localparam int CNT_W  = $clog2(N_ITER);
  localparam int MSB    = WIDTH - 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         sr_q, sr_d;
  logic               accept;

  // Single-cycle ops: returns {result, Z, C, N, V}; unknown opcodes give zero with Z set.
  function automatic logic [WIDTH+3:0] alu_eval(input logic [3:0] cmd, input logic c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             cf, vf, known;
    sum   = '0;
    r     = '0;
    cf    = 1'b0;
    vf    = 1'b0;
    known = 1'b1;
    case (cmd)
      CMD_MOV: r = b;
      CMD_MVN: r = ~b;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (cmd == CMD_ADC) ? c : 1'b0};
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, (cmd == CMD_SBC) ? c : 1'b1};
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      CMD_AND: r = a & b;
      CMD_ORR: r = a | b;
      CMD_EOR: r = a ^ b;
      default: known = 1'b0;
    endcase
    if (!known) return {{WIDTH{1'b0}}, 4'b1000};
    return {r, (r == '0), cf, r[MSB], vf};
  endfunction

  function automatic logic [3:0] mul_flags(input logic [WIDTH-1:0] p);
    return {(p == '0), 1'b0, p[MSB], 1'b0};
  endfunction

  // Partial product of the multiplicand with the low MUL_STEP multiplier bits.
  function automatic logic [WIDTH-1:0] mul_partial(input logic [WIDTH-1:0] a,
                                                   input logic [MUL_STEP-1:0] bits);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (bits[i]) p = p + (a << i);
    end
    return p;
  endfunction

  assign in_ready = !rst && (state_q == IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    vld_d    = vld_q;
    res_d    = res_q;
    sr_d     = sr_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (exe_cmd == CMD_MUL) begin
            state_d  = BUSY;
            cnt_d    = CNT_W'(N_ITER - 1);
            mcand_d  = val1;
            mplier_d = val2;
            acc_d    = '0;
          end else begin
            {res_d, sr_d} = alu_eval(exe_cmd, carry, val1, val2);
            vld_d         = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_q + mul_partial(mcand_q, mplier_q[MUL_STEP-1:0]);
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          res_d   = acc_d;
          sr_d    = mul_flags(acc_d);
          vld_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / multiplier register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      res_q    <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      sr_q     <= sr_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign sr        = sr_q;

endmodule

// File: tb/tb_alu_pipe_mul.sv
// Scoreboard bench for alu_pipe_mul: driver pushes model results on accept,
// monitor pops and compares whenever a result is consumed.
module tb_alu_pipe_mul;
  localparam int W    = 32;
  localparam int STEP = 1;
  localparam int NIT  = W / STEP;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    exe_cmd;
  logic          carry;
  logic [W-1:0]  val1;
  logic [W-1:0]  val2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    sr;

  alu_pipe_mul #(.WIDTH(W), .MUL_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .carry(carry), .val1(val1), .val2(val2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sr(sr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  bit   head_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference model: plain integer arithmetic, {result, Z, C, N, V}.
  function automatic logic [W+3:0] model(input logic [3:0] cmd, input logic c,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, full;
    longint          sa, sb, s;
    logic [W-1:0]    r;
    logic            cf, vf, cin;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    cf = 1'b0; vf = 1'b0; r = '0;
    case (cmd)
      4'd1:  r = b;
      4'd9:  r = ~b;
      4'd2, 4'd3: begin
        cin  = (cmd == 4'd3) ? c : 1'b0;
        full = ua + ub + cin;
        r    = full[31:0];
        cf   = full[32];
        s    = sa + sb + cin;
        vf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin  = (cmd == 4'd5) ? c : 1'b1;
        full = ua + (64'hFFFF_FFFF - ub) + cin;
        r    = full[31:0];
        cf   = full[32];
        s    = sa - sb - (1 - cin);
        vf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6:  r = a & b;
      4'd7:  r = a | b;
      4'd8:  r = a ^ b;
      4'd10: begin full = ua * ub; r = full[31:0]; end
      default: return {{W{1'b0}}, 4'b1000};
    endcase
    return {r, (r == 0), cf, r[W-1], vf};
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic v, input logic [3:0] cmd, input logic c,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy, output bit accepted);
    exp_t          e;
    logic [W+3:0]  m;
    in_valid  = v;
    exe_cmd   = cmd;
    carry     = c;
    val1      = a;
    val2      = b;
    out_ready = ordy;
    #1;
    accepted = in_valid && in_ready;
    if (accepted) begin
      m     = model(cmd, c, a, b);
      e.r   = m[W+3:4];
      e.f   = m[3:0];
      e.due = cyc + 1 + ((cmd == 4'd10) ? NIT : 0);
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, '0, '0, 1'b1, acc);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        head_seen = 0;
      end else if (out_valid) begin
        check("output_has_pending_op", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          if (!head_seen) begin
            check("latency_cycle", cyc, sb_q[0].due);
            head_seen = 1;
          end
          if (out_ready) begin
            check("result_sr", {result, sr}, {sb_q[0].r, sb_q[0].f});
            void'(sb_q.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int lowc, nacc;
    logic [3:0] cmd;
    rst = 1'b1; in_valid = 1'b0; exe_cmd = '0; carry = 1'b0;
    val1 = '0; val2 = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_sr", sr, 0);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b0;

    // ADD overflow, then hold with out_ready low
    drive(1'b1, 4'd2, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, acc);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_sr", sr, 4'b0011);
    check("add_ovf_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd2, 1'b0, $urandom, $urandom, 1'b0, acc);
      check("hold_result", result, 32'h8000_0000);
      check("hold_in_ready", in_ready, 0);
    end
    idle(1);

    // SUB equal, SBC with carry clear
    drive(1'b1, 4'd4, 1'b0, 32'd5, 32'd5, 1'b1, acc);
    check("sub_eq_result", result, 0);
    check("sub_eq_sr", sr, 4'b1100);
    drive(1'b1, 4'd5, 1'b0, 32'd5, 32'd3, 1'b1, acc);
    check("sbc_result", result, 1);
    check("sbc_c", sr[2], 1);
    idle(1);

    // MUL busy time and product
    drive(1'b1, 4'd10, 1'b0, 32'h0001_0003, 32'h7, 1'b1, acc);
    lowc = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) break;
      lowc++;
      drive(1'b1, 4'd2, 1'b0, 32'd1, 32'd1, 1'b1, acc);
    end
    check("mul_busy_cycles", lowc, NIT);
    check("mul_result", result, 32'h0007_0015);
    check("mul_sr", sr, 4'b0000);
    idle(1);

    // Back-to-back ADDs at full throughput
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'd2, $urandom_range(0, 1), $urandom, $urandom, 1'b1, acc);
      nacc += int'(acc);
    end
    check("b2b_accepts", nacc, 8);
    idle(2);

    // Reset in the middle of a MUL
    drive(1'b1, 4'd10, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc);
    idle(9);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_result", result, 0);
    check("midmul_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    idle(NIT + 5);
    check("after_rst_quiet", out_valid, 0);
    drive(1'b1, 4'd2, 1'b0, 32'd3, 32'd4, 1'b1, acc);
    check("after_rst_add", result, 7);
    idle(1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      cmd = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, cmd, $urandom_range(0, 1), rand_val(), rand_val(),
            $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      idle(1);
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
